// File: rtl/la_pkg.sv
// Shared types and per-sample trigger predicates for the la_trigger stage.
// Sample compare and edge tests live here so every lane evaluates identically.
package la_pkg;

    localparam int LA_DN = 2;
    localparam int LA_DW = 8;

    typedef logic [LA_DW-1:0]       smp_t;
    typedef logic [LA_DN*LA_DW-1:0] beat_t;
    typedef logic [LA_DN-1:0]       trg_t;

    function automatic logic cmp_f(smp_t s, smp_t val, smp_t msk);
        return ((s ^ val) & msk) == '0;
    endfunction

    function automatic logic edg_f(smp_t p, smp_t s, smp_t pos, smp_t neg);
        return (((~p & s) & pos) == pos) && (((p & ~s) & neg) == neg);
    endfunction

endpackage

// File: rtl/la_trigger_if.sv
// AXI4-Stream bundle carrying DN lanes of DW-bit samples per beat.
interface la_trigger_if
    import la_pkg::*;
#(
    parameter int DN = LA_DN,
    parameter int DW = LA_DW
) ();

    logic [DN*DW-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/la_trigger_lane.sv
// Combinational trigger evaluator for one sample lane.
// Edge terms exist only when LA_TRIGGER_EDGE_EN is defined.
module la_trigger_lane
    import la_pkg::*;
(
    input  smp_t s,
    input  smp_t p,
    input  logic p_valid,
    input  smp_t cfg_cmp_msk,
    input  smp_t cfg_cmp_val,
    input  smp_t cfg_edg_pos,
    input  smp_t cfg_edg_neg,
    output logic trg
);

    logic cmp;
    logic edg;

    assign cmp = cmp_f(s, cfg_cmp_val, cfg_cmp_msk);

`ifdef LA_TRIGGER_EDGE_EN
    logic no_edg;

    // Without a known predecessor only an edge-free condition can match.
    assign no_edg = (cfg_edg_pos == '0) && (cfg_edg_neg == '0);
    assign edg    = no_edg | (p_valid & edg_f(p, s, cfg_edg_pos, cfg_edg_neg));
`else
    logic unused_edg;

    assign unused_edg = ^{p, p_valid, cfg_edg_pos, cfg_edg_neg};
    assign edg        = 1'b1;
`endif

    assign trg = cmp & edg;

endmodule

// File: rtl/la_trigger.sv
// Inline trigger stage: one-beat register slice plus per-lane trigger pulse.
// LA_TRIGGER_EDGE_EN enables edge conditions and the cross-beat history.
module la_trigger
    import la_pkg::*;
#(
    parameter int DN = LA_DN,
    parameter int DW = LA_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_rst,
    input  logic [DW-1:0] cfg_cmp_msk,
    input  logic [DW-1:0] cfg_cmp_val,
    input  logic [DW-1:0] cfg_edg_pos,
    input  logic [DW-1:0] cfg_edg_neg,
    output logic [DN-1:0] sts_trg,
    la_trigger_if.slave   sti,
    la_trigger_if.master  sto
);

    logic [DN*DW-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             vld_q, vld_d;
    logic [DN-1:0]    trg_q, trg_d;
    logic [DN-1:0]    trg;
    logic [DW-1:0]    hist_q;
    logic             hist_vld_q;
    logic             xfer;

    assign sti.tready = ~vld_q | sto.tready;
    assign xfer       = sti.tvalid & sti.tready;

    for (genvar i = 0; i < DN; i++) begin : g_lane
        logic [DW-1:0] p;

        if (i == 0) begin : g_first
            assign p = hist_q;
        end else begin : g_rest
            assign p = sti.tdata[(i-1)*DW +: DW];
        end

        la_trigger_lane u_lane (
            .s           (sti.tdata[i*DW +: DW]),
            .p           (p),
            .p_valid     ((i == 0) ? hist_vld_q : 1'b1),
            .cfg_cmp_msk (cfg_cmp_msk),
            .cfg_cmp_val (cfg_cmp_val),
            .cfg_edg_pos (cfg_edg_pos),
            .cfg_edg_neg (cfg_edg_neg),
            .trg         (trg[i])
        );
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        trg_d  = '0;
        if (xfer) begin
            vld_d  = 1'b1;
            data_d = sti.tdata;
            last_d = sti.tlast;
            trg_d  = trg;
        end else if (sto.tready) begin
            vld_d  = 1'b0;
        end
        if (ctl_rst) begin
            vld_d  = 1'b0;
            data_d = '0;
            last_d = 1'b0;
            trg_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            trg_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            trg_q  <= trg_d;
        end
    end

`ifdef LA_TRIGGER_EDGE_EN
    logic [DW-1:0] hist_d;
    logic          hist_vld_d;

    // History tracks the newest lane of the last accepted beat.
    always_comb begin
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        if (xfer) begin
            hist_d     = sti.tdata[(DN-1)*DW +: DW];
            hist_vld_d = 1'b1;
        end
        if (ctl_rst) begin
            hist_d     = '0;
            hist_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
        end
    end
`else
    assign hist_q     = '0;
    assign hist_vld_q = 1'b0;
`endif

    assign sto.tdata  = data_q;
    assign sto.tlast  = last_q;
    assign sto.tvalid = vld_q;
    assign sts_trg    = trg_q;

endmodule

// File: tb/tb_la_trigger.sv
// Self-checking bench for la_trigger against a queue-based reference model.
module tb_la_trigger;

    localparam int DN = 2;
    localparam int DW = 8;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_s;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_rst;
    logic [DW-1:0] cfg_cmp_msk;
    logic [DW-1:0] cfg_cmp_val;
    logic [DW-1:0] cfg_edg_pos;
    logic [DW-1:0] cfg_edg_neg;
    logic [DN-1:0] sts_trg;

    la_trigger_if #(.DN(DN), .DW(DW)) sti ();
    la_trigger_if #(.DN(DN), .DW(DW)) sto ();

    la_trigger #(.DN(DN), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctl_rst     (ctl_rst),
        .cfg_cmp_msk (cfg_cmp_msk),
        .cfg_cmp_val (cfg_cmp_val),
        .cfg_edg_pos (cfg_edg_pos),
        .cfg_edg_neg (cfg_edg_neg),
        .sts_trg     (sts_trg),
        .sti         (sti),
        .sto         (sto)
    );

    always #5 clk = ~clk;

`ifdef LA_TRIGGER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    beat_s      exq[$];
    logic [7:0] m_prev;
    bit         m_pvld;
    bit         m_xfer;
    int         m_pops;

    logic        obs_rdy, obs_vld, obs_last;
    logic [15:0] obs_data;
    logic [1:0]  obs_trg;
    logic        exp_rdy, exp_vld, exp_last;
    logic [15:0] exp_data;
    logic [1:0]  exp_trg;

    function automatic logic [1:0] ref_trg(input logic [15:0] d);
        logic [1:0] r;
        logic [7:0] s, p;
        bit         cmp, edg, pv;
        r = '0;
        for (int i = 0; i < DN; i++) begin
            s   = d[i*8 +: 8];
            p   = (i == 0) ? m_prev : d[(i-1)*8 +: 8];
            pv  = (i == 0) ? m_pvld : 1'b1;
            cmp = 1'b1;
            edg = 1'b1;
            for (int b = 0; b < DW; b++) begin
                if (cfg_cmp_msk[b] && s[b] != cfg_cmp_val[b]) cmp = 1'b0;
                if (EDGE && cfg_edg_pos[b] && !(!p[b] && s[b])) edg = 1'b0;
                if (EDGE && cfg_edg_neg[b] && !(p[b] && !s[b])) edg = 1'b0;
            end
            if (EDGE && !pv && (cfg_edg_pos != 0 || cfg_edg_neg != 0))
                edg = 1'b0;
            r[i] = cmp && edg;
        end
        return r;
    endfunction

    // One clock of stimulus; leaves observed and predicted values behind.
    task automatic cycle(input bit vld, input logic [15:0] d,
                         input bit last, input bit rdy, input bit crst);
        logic [1:0] t;
        sti.tvalid = vld;
        sti.tdata  = d;
        sti.tlast  = last;
        sto.tready = rdy;
        ctl_rst    = crst;
        #1;
        obs_rdy = sti.tready;
        exp_rdy = (exq.size() == 0) || rdy;
        m_xfer  = vld && exp_rdy && !crst;
        t       = m_xfer ? ref_trg(d) : 2'b00;
        @(posedge clk);
        if (crst) begin
            exq.delete();
            m_pvld  = 1'b0;
            m_prev  = '0;
            exp_trg = '0;
        end else begin
            if (exq.size() > 0 && rdy) begin
                exq.delete(0);
                m_pops++;
            end
            if (m_xfer) begin
                exq.push_back('{d: d, l: last});
                m_prev = d[15:8];
                m_pvld = 1'b1;
            end
            exp_trg = t;
        end
        #1;
        obs_vld  = sto.tvalid;
        obs_data = sto.tdata;
        obs_last = sto.tlast;
        obs_trg  = sts_trg;
        exp_vld  = exq.size() > 0;
        exp_data = exp_vld ? exq[0].d : 16'h0;
        exp_last = exp_vld ? exq[0].l : 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sti.tvalid = 1'b0;
        sti.tdata  = '0;
        sti.tlast  = 1'b0;
        sto.tready = 1'b0;
        ctl_rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sti.tready, sto.tvalid, sto.tlast, sts_trg, sto.tdata}
            !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0}) begin
            errors++;
            $display("FAIL reset rdy/vld/last/trg/data act=%b%b%b %b %h",
                     sti.tready, sto.tvalid, sto.tlast, sts_trg, sto.tdata);
        end
        @(negedge clk);
        rst = 1'b0;
        exq.delete();
        m_prev = '0;
        m_pvld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp(input string nm, input logic [7:0] val,
                             input logic [7:0] pos, input logic [7:0] neg,
                             input logic [1:0] hit);
        cfg_cmp_msk = 8'hFF;
        cfg_cmp_val = val;
        cfg_edg_pos = pos;
        cfg_edg_neg = neg;
        cycle(0, '0, 0, 1, 1);
        for (int b = 0; b < 8; b++) begin
            cycle(1, {8'(2*b+1), 8'(2*b)}, b == 7, 1, 0);
            checks++;
            if ({obs_rdy, obs_vld, obs_trg} !== {exp_rdy, exp_vld, exp_trg}) begin
                errors++;
                $display("FAIL %s ctl act=%b%b %b req=%b%b %b", nm,
                         obs_rdy, obs_vld, obs_trg, exp_rdy, exp_vld, exp_trg);
            end
            checks++;
            if ({obs_last, obs_data, obs_trg}
                !== {b == 7, 8'(2*b+1), 8'(2*b), (b == 4) ? hit : 2'b00}) begin
                errors++;
                $display("FAIL %s beat%0d act=%b %h %b", nm, b,
                         obs_last, obs_data, obs_trg);
            end
        end
        cycle(0, '0, 0, 1, 0);
    endtask

    task automatic test_edge_across();
        logic [1:0] req1, req2;
        cfg_cmp_msk = 8'h00;
        cfg_cmp_val = 8'h00;
        cfg_edg_pos = 8'h01;
        cfg_edg_neg = 8'h00;
        req1 = EDGE ? 2'b00 : 2'b11;
        req2 = EDGE ? 2'b01 : 2'b11;
        cycle(0, '0, 0, 1, 1);
        cycle(1, 16'h0402, 0, 1, 0);
        checks++;
        if (obs_trg !== req1 || obs_trg !== exp_trg) begin
            errors++;
            $display("FAIL edge_beat1 act=%b req=%b", obs_trg, req1);
        end
        cycle(1, 16'h0605, 1, 1, 0);
        checks++;
        if (obs_trg !== req2 || obs_trg !== exp_trg) begin
            errors++;
            $display("FAIL edge_beat2 act=%b req=%b", obs_trg, req2);
        end
        cycle(0, '0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        int k;
        cfg_cmp_msk = 8'hFF;
        cfg_cmp_val = 8'h03;
        cfg_edg_pos = 8'h00;
        cfg_edg_neg = 8'h00;
        cycle(0, '0, 0, 1, 1);
        m_pops = 0;
        k = 0;
        for (int c = 0; c < 16; c++) begin
            cycle(k < 6, {8'(2*k+1), 8'(2*k)}, k == 5, !(c inside {3, 4, 5}), 0);
            if (m_xfer) k++;
            checks++;
            if ({obs_rdy, obs_vld, obs_trg} !== {exp_rdy, exp_vld, exp_trg}) begin
                errors++;
                $display("FAIL bp ctl c%0d act=%b%b %b req=%b%b %b", c,
                         obs_rdy, obs_vld, obs_trg, exp_rdy, exp_vld, exp_trg);
            end
            if (exp_vld) begin
                checks++;
                if ({obs_last, obs_data} !== {exp_last, exp_data}) begin
                    errors++;
                    $display("FAIL bp data c%0d act=%b %h req=%b %h", c,
                             obs_last, obs_data, exp_last, exp_data);
                end
            end
        end
        checks++;
        if (m_pops !== 6 || k !== 6) begin
            errors++;
            $display("FAIL bp count act=%0d/%0d req=6", k, m_pops);
        end
    endtask

    task automatic test_ctl_rst();
        cfg_cmp_msk = 8'h00;
        cfg_cmp_val = 8'h00;
        cfg_edg_pos = 8'h01;
        cfg_edg_neg = 8'h00;
        for (int b = 0; b < 3; b++) cycle(1, {8'(b+1), 8'(b)}, 0, 1, 0);
        cycle(1, 16'h0807, 0, 1, 1);
        checks++;
        if ({obs_vld, obs_trg, obs_data} !== {1'b0, 2'b00, 16'h0}) begin
            errors++;
            $display("FAIL ctlrst flush act=%b %b %h", obs_vld, obs_trg, obs_data);
        end
        cycle(1, 16'h0201, 1, 1, 0);
        checks++;
        if (obs_trg !== (EDGE ? 2'b00 : 2'b11) || obs_trg !== exp_trg) begin
            errors++;
            $display("FAIL ctlrst first act=%b model=%b", obs_trg, exp_trg);
        end
        cycle(0, '0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int n;
        cfg_cmp_msk = 8'h0F;
        cfg_cmp_val = 8'h05;
        cfg_edg_pos = 8'h00;
        cfg_edg_neg = 8'h00;
        n = 0;
        for (int b = 0; b < 8; b++) begin
            cycle(1, {8'(b+2), 8'(b)}, b == 7, 1, 0);
            if (m_xfer) n++;
            checks++;
            if ({obs_rdy, obs_vld, obs_trg, obs_data}
                !== {1'b1, 1'b1, exp_trg, exp_data}) begin
                errors++;
                $display("FAIL b2b b%0d act=%b%b %b %h req=%b %h", b,
                         obs_rdy, obs_vld, obs_trg, obs_data, exp_trg, exp_data);
            end
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL b2b throughput act=%0d req=8", n);
        end
        cycle(0, '0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int e = 0; e < 6; e++) begin
            cycle(0, '0, 0, 1, 0);
            cfg_cmp_msk = 8'($urandom) & 8'($urandom) & 8'h0F;
            cfg_cmp_val = 8'($urandom_range(0, 15));
            cfg_edg_pos = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 3));
            cfg_edg_neg = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 3));
            for (int c = 0; c < 50; c++) begin
                cycle($urandom_range(0, 3) != 0,
                      {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))},
                      $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 39) == 0);
                checks++;
                if ({obs_rdy, obs_vld, obs_trg} !== {exp_rdy, exp_vld, exp_trg}) begin
                    errors++;
                    $display("FAIL rnd ctl e%0d c%0d act=%b%b %b req=%b%b %b", e, c,
                             obs_rdy, obs_vld, obs_trg, exp_rdy, exp_vld, exp_trg);
                end
                if (exp_vld) begin
                    checks++;
                    if ({obs_last, obs_data} !== {exp_last, exp_data}) begin
                        errors++;
                        $display("FAIL rnd data e%0d c%0d act=%b %h req=%b %h", e, c,
                                 obs_last, obs_data, exp_last, exp_data);
                    end
                end
            end
        end
    endtask

    initial begin
        cfg_cmp_msk = '0;
        cfg_cmp_val = '0;
        cfg_edg_pos = '0;
        cfg_edg_neg = '0;
        m_pops      = 0;
        test_reset();
        test_ramp("ramp_neg", 8'h08, 8'h00, 8'h01, 2'b01);
        test_ramp("ramp_pos", 8'h09, 8'h01, 8'h00, 2'b10);
        test_edge_across();
        test_backpressure();
        test_ctl_rst();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
